// File: rtl/blake3_chunk_feeder_if.sv
// Chunk feeder bus: message word stream in, per-block HashGen request/result, digest out.
// The slave side is the feeder; the master side is the word source plus HashGen.
interface blake3_chunk_feeder_if;
    logic [31:0]  Word_I;
    logic         WVld_I;
    logic         WLast_I;
    logic [2:0]   WBytes_I;
    logic         WRdy_O;
    logic         Strt_O;
    logic [31:0]  BL_O;
    logic         CS_flg_O;
    logic         CE_flg_O;
    logic         ROOT_flg_O;
    logic [255:0] H_O;
    logic [511:0] Msg_O;
    logic         Vld_I;
    logic [255:0] H_I;
    logic [255:0] Dgst_O;
    logic         DVld_O;
    logic         Err_O;

    modport slave (
        input  Word_I, WVld_I, WLast_I, WBytes_I, Vld_I, H_I,
        output WRdy_O, Strt_O, BL_O, CS_flg_O, CE_flg_O, ROOT_flg_O, H_O, Msg_O,
               Dgst_O, DVld_O, Err_O
    );

    modport master (
        output Word_I, WVld_I, WLast_I, WBytes_I, Vld_I, H_I,
        input  WRdy_O, Strt_O, BL_O, CS_flg_O, CE_flg_O, ROOT_flg_O, H_O, Msg_O,
               Dgst_O, DVld_O, Err_O
    );
endinterface

// File: rtl/blake3_chunk_feeder.sv
// Packs a one-chunk little-endian word stream into zero-padded 16-word BLAKE3 blocks,
// drives HashGen once per block with flags and chaining value, and emits the final digest.
//   state | meaning
//   FILL  | accepting words into the block buffer
//   START | one-cycle start pulse to HashGen
//   WAIT  | block inputs held, waiting for Vld_I
//   DONE  | digest valid for one cycle
module blake3_chunk_feeder #(
    parameter int unsigned  MAX_BLOCKS = 16,
    parameter logic [255:0] IV_INIT    = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                          32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667}
) (
    input logic                  Clk,
    input logic                  Rst,
    blake3_chunk_feeder_if.slave bus
);
    localparam int BW = $clog2(MAX_BLOCKS);

    typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [15:0][31:0]   msg_q, msg_d;
    logic [3:0]          widx_q, widx_d;
    logic [BW-1:0]       blk_q, blk_d;
    logic [6:0]          bl_q, bl_d;
    logic                cs_q, cs_d;
    logic                fin_q, fin_d;
    logic [255:0]        chain_q, chain_d;
    logic [255:0]        dgst_q, dgst_d;
    logic                err_q, err_d;
    logic                drop_q, drop_d;

    logic [2:0]          nbytes;
    logic [31:0]         byte_mask;
    logic [31:0]         word_in;
    logic                last_blk;
    logic                close_blk;
    logic                wrdy, strt, dvld;

    // WBytes_I of 0 (and out-of-range codes) mean a full word
    always_comb begin
        nbytes = (bus.WBytes_I == 3'd0 || bus.WBytes_I > 3'd4) ? 3'd4 : bus.WBytes_I;
        case (nbytes)
            3'd1:    byte_mask = 32'h0000_00ff;
            3'd2:    byte_mask = 32'h0000_ffff;
            3'd3:    byte_mask = 32'h00ff_ffff;
            default: byte_mask = 32'hffff_ffff;
        endcase
        word_in   = bus.WLast_I ? (bus.Word_I & byte_mask) : bus.Word_I;
        last_blk  = (blk_q == BW'(MAX_BLOCKS - 1));
        close_blk = (state_q == S_FILL) && bus.WVld_I && !drop_q &&
                    (bus.WLast_I || widx_q == 4'd15);
    end

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (close_blk) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (bus.Vld_I) state_d = fin_q ? S_DONE : S_FILL;
            S_DONE:  state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        wrdy = 1'b0;
        strt = 1'b0;
        dvld = 1'b0;
        case (state_q)
            S_FILL:  wrdy = 1'b1;
            S_START: strt = 1'b1;
            S_DONE:  dvld = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        msg_d   = msg_q;
        widx_d  = widx_q;
        blk_d   = blk_q;
        bl_d    = bl_q;
        cs_d    = cs_q;
        fin_d   = fin_q;
        chain_d = chain_q;
        dgst_d  = dgst_q;
        err_d   = err_q;
        drop_d  = drop_q;
        case (state_q)
            S_FILL: begin
                if (bus.WVld_I) begin
                    if (drop_q) begin
                        // overlong message: swallow words until its last one
                        if (bus.WLast_I) drop_d = 1'b0;
                    end else begin
                        msg_d[widx_q] = word_in;
                        widx_d        = widx_q + 4'd1;
                        if (close_blk) begin
                            widx_d = 4'd0;
                            bl_d   = bus.WLast_I ? (7'({widx_q, 2'b00}) + 7'(nbytes)) : 7'd64;
                            cs_d   = (blk_q == '0);
                            fin_d  = bus.WLast_I || last_blk;
                            if (!bus.WLast_I && last_blk) begin
                                err_d  = 1'b1;
                                drop_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_WAIT: begin
                if (bus.Vld_I) begin
                    chain_d = bus.H_I;
                    msg_d   = '0;
                    if (fin_q) dgst_d = bus.H_I;
                    else       blk_d  = blk_q + BW'(1);
                end
            end
            S_DONE: begin
                blk_d   = '0;
                chain_d = IV_INIT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            msg_q   <= '0;
            widx_q  <= '0;
            blk_q   <= '0;
            bl_q    <= '0;
            cs_q    <= 1'b0;
            fin_q   <= 1'b0;
            chain_q <= IV_INIT;
            dgst_q  <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            msg_q   <= msg_d;
            widx_q  <= widx_d;
            blk_q   <= blk_d;
            bl_q    <= bl_d;
            cs_q    <= cs_d;
            fin_q   <= fin_d;
            chain_q <= chain_d;
            dgst_q  <= dgst_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.WRdy_O     = wrdy;
    assign bus.Strt_O     = strt;
    assign bus.DVld_O     = dvld;
    assign bus.BL_O       = {25'd0, bl_q};
    assign bus.CS_flg_O   = cs_q;
    assign bus.CE_flg_O   = fin_q;
    assign bus.ROOT_flg_O = fin_q;
    assign bus.H_O        = chain_q;
    assign bus.Msg_O      = msg_q;
    assign bus.Dgst_O     = dgst_q;
    assign bus.Err_O      = err_q;
endmodule

// File: tb/tb_blake3_chunk_feeder.sv
// Bench for blake3_chunk_feeder: a BLAKE3-compressing HashGen responder plus a
// message-level reference model that predicts every block and digest.
`timescale 1ns/1ps
module tb_blake3_chunk_feeder;
    localparam logic [255:0] IV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                   32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
    localparam logic [255:0] ABC_DGST = 256'h859dbdd5_6c9c35fd_03db795d_4658c548_b58d3a27_753bb6ff_33514638_acb33764;

    typedef logic [31:0] w16_t [16];
    typedef struct {
        logic [511:0] msg;
        logic [31:0]  bl;
        logic         cs;
        logic         ce;
        logic         root;
        logic [255:0] h;
    } blk_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    blake3_chunk_feeder_if bus();
    blake3_chunk_feeder dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    always #5 Clk = ~Clk;

    int           n_vec = 0;
    int           n_err = 0;
    int           dvld_cnt = 0;
    blk_t         exp_blk[$];
    logic [255:0] exp_dgst[$];
    logic         hg_auto = 1'b1;
    logic         hg_vld = 1'b0;
    logic         man_vld = 1'b0;
    logic [255:0] hg_h = '0;
    logic [255:0] man_h = '0;

    assign bus.Vld_I = hg_vld | man_vld;
    assign bus.H_I   = man_vld ? man_h : hg_h;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic w16_t g(input w16_t v, input int a, input int b, input int c, input int d,
                               input logic [31:0] x, input logic [31:0] y);
        w16_t r;
        r = v;
        r[a] = r[a] + r[b] + x;  r[d] = ror(r[d] ^ r[a], 16);
        r[c] = r[c] + r[d];      r[b] = ror(r[b] ^ r[c], 12);
        r[a] = r[a] + r[b] + y;  r[d] = ror(r[d] ^ r[a], 8);
        r[c] = r[c] + r[d];      r[b] = ror(r[b] ^ r[c], 7);
        return r;
    endfunction

    // BLAKE3 compression (counter 0), returning the 8-word chaining value
    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] m,
                                              input logic [31:0] bl, input logic [31:0] fl);
        w16_t v, mw, t;
        int perm[16];
        logic [255:0] o;
        perm = '{2, 6, 3, 10, 7, 0, 4, 13, 1, 11, 12, 5, 9, 14, 15, 8};
        for (int i = 0; i < 8; i++) v[i] = h[32*i +: 32];
        for (int i = 0; i < 4; i++) v[8+i] = IV[32*i +: 32];
        v[12] = '0; v[13] = '0; v[14] = bl; v[15] = fl;
        for (int i = 0; i < 16; i++) mw[i] = m[32*i +: 32];
        for (int r = 0; r < 7; r++) begin
            v = g(v, 0, 4,  8, 12, mw[0],  mw[1]);
            v = g(v, 1, 5,  9, 13, mw[2],  mw[3]);
            v = g(v, 2, 6, 10, 14, mw[4],  mw[5]);
            v = g(v, 3, 7, 11, 15, mw[6],  mw[7]);
            v = g(v, 0, 5, 10, 15, mw[8],  mw[9]);
            v = g(v, 1, 6, 11, 12, mw[10], mw[11]);
            v = g(v, 2, 7,  8, 13, mw[12], mw[13]);
            v = g(v, 3, 4,  9, 14, mw[14], mw[15]);
            if (r < 6) begin
                t = mw;
                for (int i = 0; i < 16; i++) mw[i] = t[perm[i]];
            end
        end
        for (int i = 0; i < 8; i++) o[32*i +: 32] = v[i] ^ v[i+8];
        return o;
    endfunction

    // Message-level prediction: split into 16-word blocks, at most 16 of them
    task automatic model(input logic [31:0] words[$], input bit has_last,
                         input logic [2:0] lbytes, input bit want_dgst);
        logic [255:0] chain;
        logic [31:0]  w;
        blk_t         b;
        int           n, nb, first, cnt, bytes;
        bit           fin, ends_here;
        chain = IV;
        n     = words.size();
        bytes = (lbytes == 3'd0 || lbytes > 3'd4) ? 4 : int'(lbytes);
        nb    = (n + 15) / 16;
        if (nb > 16) nb = 16;
        for (int k = 0; k < nb; k++) begin
            first     = 16 * k;
            cnt       = (n - first < 16) ? n - first : 16;
            ends_here = has_last && (first + cnt == n);
            b.msg     = '0;
            for (int j = 0; j < cnt; j++) begin
                w = words[first + j];
                if (ends_here && j == cnt - 1 && bytes < 4)
                    w = w & ((32'h1 << (8 * bytes)) - 32'h1);
                b.msg[32*j +: 32] = w;
            end
            fin    = ends_here || (k == 15);
            b.bl   = ends_here ? 32'(4 * (cnt - 1) + bytes) : 32'd64;
            b.cs   = (k == 0);
            b.ce   = fin;
            b.root = fin;
            b.h    = chain;
            chain  = compress(chain, b.msg, b.bl, {28'd0, fin, 1'b0, fin, b.cs});
            exp_blk.push_back(b);
            if (fin) break;
        end
        if (want_dgst) exp_dgst.push_back(chain);
    endtask

    // HashGen stand-in: compresses whatever block the feeder presents
    initial begin
        logic [255:0] r;
        int lat;
        forever begin
            @(negedge Clk);
            if (bus.Strt_O && hg_auto && !Rst) begin
                r   = compress(bus.H_O, bus.Msg_O, bus.BL_O,
                               {28'd0, bus.ROOT_flg_O, 1'b0, bus.CE_flg_O, bus.CS_flg_O});
                lat = $urandom_range(1, 5);
                repeat (lat) @(negedge Clk);
                hg_h   = r;
                hg_vld = 1'b1;
                @(negedge Clk);
                hg_vld = 1'b0;
            end
        end
    end

    initial begin
        blk_t b;
        forever begin
            @(negedge Clk);
            if (!Rst && bus.Strt_O) begin
                chk("wrdy_in_start", 512'(bus.WRdy_O), 512'(1'b0));
                if (exp_blk.size() == 0) begin
                    chk("unexpected_strt", 512'(bus.Strt_O), 512'(1'b0));
                end else begin
                    b = exp_blk.pop_front();
                    chk("bl",   512'(bus.BL_O), 512'(b.bl));
                    chk("cs",   512'(bus.CS_flg_O), 512'(b.cs));
                    chk("ce",   512'(bus.CE_flg_O), 512'(b.ce));
                    chk("root", 512'(bus.ROOT_flg_O), 512'(b.root));
                    chk("h_in", 512'(bus.H_O), 512'(b.h));
                    chk("msg",  bus.Msg_O, b.msg);
                end
            end
            if (!Rst && bus.DVld_O) begin
                dvld_cnt++;
                if (exp_dgst.size() == 0) chk("unexpected_dvld", 512'(bus.DVld_O), 512'(1'b0));
                else                      chk("dgst", 512'(bus.Dgst_O), 512'(exp_dgst.pop_front()));
            end
        end
    end

    task automatic send(input logic [31:0] words[$], input bit has_last,
                        input logic [2:0] lbytes, input bit gaps);
        bit ok;
        int guard;
        for (int i = 0; i < words.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(negedge Clk);
                bus.WVld_I = 1'b0;
            end
            ok    = 1'b0;
            guard = 0;
            while (!ok && guard < 200) begin
                @(negedge Clk);
                bus.WVld_I   = 1'b1;
                bus.Word_I   = words[i];
                bus.WLast_I  = has_last && (i == words.size() - 1);
                bus.WBytes_I = lbytes;
                ok           = bus.WRdy_O;
                guard++;
            end
            if (!ok) chk("word_accept_timeout", 512'(ok), 512'(1'b1));
        end
        @(negedge Clk);
        bus.WVld_I  = 1'b0;
        bus.WLast_I = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((exp_blk.size() != 0 || exp_dgst.size() != 0) && guard < 3000) begin
            @(negedge Clk);
            guard++;
        end
        chk("drain_timeout", 512'(exp_blk.size() + exp_dgst.size()), 512'(0));
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] part[$];
        logic [2:0]  lb;
        int          len, guard, dv0;

        bus.Word_I = '0; bus.WVld_I = 1'b0; bus.WLast_I = 1'b0; bus.WBytes_I = '0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_wrdy", 512'(bus.WRdy_O), 512'(1'b1));
        chk("rst_strt", 512'(bus.Strt_O), 512'(1'b0));
        chk("rst_bl",   512'(bus.BL_O), 512'(0));
        chk("rst_flags", 512'({bus.CS_flg_O, bus.CE_flg_O, bus.ROOT_flg_O}), 512'(3'b000));
        chk("rst_h",    512'(bus.H_O), 512'(IV));
        chk("rst_msg",  bus.Msg_O, 512'(0));
        chk("rst_dgst", 512'(bus.Dgst_O), 512'(0));
        chk("rst_dvld", 512'(bus.DVld_O), 512'(1'b0));
        chk("rst_err",  512'(bus.Err_O), 512'(1'b0));
        Rst = 1'b0;
        @(negedge Clk);

        // "abc"
        q = '{32'h00636261};
        model(q, 1'b1, 3'd3, 1'b1);
        send(q, 1'b1, 3'd3, 1'b0);
        wait_idle();
        chk("abc_dgst_w0", 512'(bus.Dgst_O[31:0]), 512'(32'hacb33764));
        chk("abc_dgst",    512'(bus.Dgst_O), 512'(ABC_DGST));

        // exactly 16 words, then 17 words
        for (int n = 16; n <= 17; n++) begin
            q.delete();
            for (int i = 0; i < n; i++) q.push_back($urandom);
            model(q, 1'b1, 3'd4, 1'b1);
            send(q, 1'b1, 3'd4, 1'b1);
            wait_idle();
        end

        // single word with partial byte counts, including the 0-means-4 encoding
        for (int k = 0; k < 5; k++) begin
            q = '{32'hDEADBEEF};
            lb = 3'(k);
            model(q, 1'b1, lb, 1'b1);
            send(q, 1'b1, lb, 1'b0);
            wait_idle();
        end

        // back-to-back random messages; WVld_I stays high across START/WAIT
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 48);
            lb  = 3'($urandom_range(0, 4));
            q.delete();
            for (int i = 0; i < len; i++) q.push_back($urandom);
            model(q, 1'b1, lb, 1'b1);
            send(q, 1'b1, lb, r[0]);
        end
        wait_idle();

        // stray Vld_I in the middle of a fill must not disturb it
        q.delete();
        part.delete();
        for (int i = 0; i < 20; i++) q.push_back($urandom);
        for (int i = 0; i < 7; i++) part.push_back(q[i]);
        model(q, 1'b1, 3'd2, 1'b1);
        send(part, 1'b0, 3'd4, 1'b0);
        man_h = {8{$urandom}};
        man_vld = 1'b1;
        @(negedge Clk);
        man_vld = 1'b0;
        @(negedge Clk);
        chk("stray_vld_wrdy", 512'(bus.WRdy_O), 512'(1'b1));
        part.delete();
        for (int i = 7; i < 20; i++) part.push_back(q[i]);
        send(part, 1'b1, 3'd2, 1'b0);
        wait_idle();

        // reset while waiting on HashGen, then a stale result
        hg_auto = 1'b0;
        dv0 = dvld_cnt;
        q = '{32'h00636261};
        model(q, 1'b1, 3'd3, 1'b0);
        send(q, 1'b1, 3'd3, 1'b0);
        guard = 0;
        while (exp_blk.size() != 0 && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        chk("rst_wait_strt_timeout", 512'(exp_blk.size()), 512'(0));
        @(negedge Clk);
        chk("wait_wrdy", 512'(bus.WRdy_O), 512'(1'b0));
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        man_h = {8{$urandom}};
        man_vld = 1'b1;
        @(negedge Clk);
        man_vld = 1'b0;
        repeat (5) @(negedge Clk);
        chk("rst_wait_no_dvld", 512'(dvld_cnt), 512'(dv0));
        chk("rst_wait_wrdy", 512'(bus.WRdy_O), 512'(1'b1));
        chk("rst_wait_h", 512'(bus.H_O), 512'(IV));
        hg_auto = 1'b1;
        model(q, 1'b1, 3'd3, 1'b1);
        send(q, 1'b1, 3'd3, 1'b0);
        wait_idle();
        chk("abc_after_rst", 512'(bus.Dgst_O), 512'(ABC_DGST));

        // 256 words with no last: 16th block is final and Err_O sets
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back($urandom);
        model(q, 1'b0, 3'd4, 1'b1);
        send(q, 1'b0, 3'd4, 1'b0);
        wait_idle();
        chk("err_256", 512'(bus.Err_O), 512'(1'b1));
        q = '{$urandom, $urandom, $urandom};
        send(q, 1'b1, 3'd4, 1'b0);
        repeat (10) @(negedge Clk);
        chk("err_held_tail", 512'(bus.Err_O), 512'(1'b1));
        q = '{32'h00636261};
        model(q, 1'b1, 3'd3, 1'b1);
        send(q, 1'b1, 3'd3, 1'b0);
        wait_idle();
        chk("err_held_abc", 512'(bus.Err_O), 512'(1'b1));
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk("err_cleared", 512'(bus.Err_O), 512'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/blake3_chunk_feeder.md
Name: blake3_chunk_feeder

Overview:
Front end of the hashing core. It accepts a little-endian 32-bit word stream for one message of up to 1024 bytes (one BLAKE3 chunk) and packs it into zero-padded 16-word blocks. For each block it drives HashGen with a 1-cycle start pulse, byte length and CS/CE/ROOT flags, and carries the chaining value from block to block. When the final compression completes, it emits the 256-bit digest.

Parameters:
MAX_BLOCKS, 16, blocks per message (one chunk); 17th block never issued.
IV_INIT, {`IV_7..`IV_0}, 256-bit chaining value for block 0, from defines.sv.

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous reset, active-high
Word_I  in  32  message word, byte 0 = bits [7:0]
WVld_I  in  1  Word_I valid
WLast_I  in  1  last word of message
WBytes_I  in  3  valid bytes in last word (1..4); sampled only with WLast_I
WRdy_O  out  1  feeder can accept a word
Strt_O  out  1  1-cycle start pulse to HashGen
BL_O  out  32  block byte length (1..64)
CS_flg_O  out  1  chunk start (block 0)
CE_flg_O  out  1  chunk end (final block)
ROOT_flg_O  out  1  root (final block)
H_O  out  256  chaining value in, word i at [32i+31:32i]
Msg_O  out  512  block words 0..15, word i at [32i+31:32i]
Vld_I  in  1  HashGen result valid
H_I  in  256  HashGen result H0..H7
Dgst_O  out  256  final digest
DVld_O  out  1  1-cycle digest valid
Err_O  out  1  sticky: 256 words received without WLast_I

Behaviour:
- Single clock domain; Rst is synchronous, active-high and overrides everything.
- Reset values: WRdy_O=1, Strt_O=0, BL_O=0, flags=0, H_O=IV_INIT, Msg_O=0, Dgst_O=0, DVld_O=0, Err_O=0. Internal state: FSM=FILL, word idx=0, block idx=0.
- FSM states: FILL, START, WAIT, DONE.
- FILL:
  - WRdy_O=1; a word is accepted when WVld_I&WRdy_O.
  - Word is stored at word idx; idx increments.
  - Block closes on an accepted word when WLast_I=1, or when idx=15; then go to START.
- Last-word masking: bytes at position >= WBytes_I are forced to 0. WBytes_I=0 is treated as 4.
- Padding: unused words of the final block are 0.
- BL_O:
  - Non-final block: 64.
  - Final block: 4*idx_of_last_word + WBytes_I.
- Final block: the block closed by WLast_I, or block idx=MAX_BLOCKS-1. The latter without WLast_I sets Err_O; any further words until WLast_I are accepted and discarded.
- Flags: CS_flg_O=(block idx==0). CE_flg_O=ROOT_flg_O=final.
- H_O: IV_INIT for block 0, else the latched chaining value.
- START: Strt_O=1 for exactly one cycle, in the cycle after the closing word is accepted; go to WAIT.
- WAIT:
  - WRdy_O=0; Msg_O, BL_O, flags and H_O are held stable.
  - On Vld_I, latch H_I into the chaining register.
  - If non-final: clear the word buffer, block idx++, go to FILL (WRdy_O=1 next cycle).
  - If final: go to DONE.
- DONE (one cycle):
  - Dgst_O=latched H_I and DVld_O=1, i.e. the cycle after Vld_I.
  - Block idx=0, chaining=IV_INIT, go to FILL.
  - Dgst_O holds until the next digest.
- Vld_I outside WAIT is ignored, including a stale result after reset.
- Reset mid-operation: state returns to FILL; the partial message is discarded.
- WRdy_O is 0 in START/WAIT/DONE; words presented then are not consumed.

Test Plan:
1. Message "abc": Word_I=0x00636261, WLast_I=1, WBytes_I=3.
   - Required: Strt_O next cycle; BL_O=3; CS=CE=ROOT=1; Msg word0=0x00636261, others 0; H_O=IV.
   - With a reference HashGen: Dgst word0=0xacb33764, digest bytes 6437b3ac…bd9d85.
2. 16 words, WLast_I on the 16th, WBytes_I=4 -> exactly one Strt_O; BL_O=64; CS=CE=ROOT=1.
3. 17 words, last WBytes_I=4:
   - Block 0: BL_O=64, CS=1, CE=ROOT=0, H_O=IV.
   - Block 1: BL_O=4, CS=0, CE=ROOT=1, H_O=H_I returned for block 0; Msg word0=17th word.
4. Single word 0xDEADBEEF with WBytes_I=1 -> Msg word0=0x000000EF, BL_O=1. With WBytes_I=2 -> 0x0000BEEF, BL_O=2.
5. WVld_I held high through START/WAIT -> WRdy_O=0, no word lost or duplicated (verify Msg_O of the next block). Vld_I pulsed during FILL -> no state change.
6. Two further cases:
   - Assert Rst while in WAIT, then pulse Vld_I -> no DVld_O. A new "abc" yields H_O=IV and the correct digest.
   - 256 words with no WLast_I -> 16th block has CE=ROOT=1 and Err_O=1, held until Rst.
